// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Sized for a four-digit display fed from a 14-bit binary count.
package bin_to_bcd_seq_pkg;

  localparam int BIN_W   = 14;
  localparam int DIGITS  = 4;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int MAX_VAL = 9999;
  localparam int CNT_W   = $clog2(BIN_W);

  localparam logic [BCD_W-1:0] SAT_BCD = 16'h9999;
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a client and the BCD converter.
// master drives the request, slave returns the registered result.
interface bin_to_bcd_seq_if;
  import bin_to_bcd_seq_pkg::*;

  logic             Start;
  logic [BIN_W-1:0] Bin;
  logic [BCD_W-1:0] BCD;
  logic             Busy;
  logic             Done;
  logic             Overflow;

  modport master (
    output Start,
    output Bin,
    input  BCD,
    input  Busy,
    input  Done,
    input  Overflow
  );

  modport slave (
    input  Start,
    input  Bin,
    output BCD,
    output Busy,
    output Done,
    output Overflow
  );

endinterface

// File: rtl/bin_to_bcd_seq_dabble_digit.sv
// One BCD digit corrector for shift-and-add-3.
// A digit of 5 or more would overflow past 9 when doubled, so add 3.
module dabble_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock.
// Result registers update only on the Done edge, so displays never glitch.
module bin_to_bcd_seq (
  input  logic             CLK,
  input  logic             Reset,
  bin_to_bcd_seq_if.slave  bus
);
  import bin_to_bcd_seq_pkg::*;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BIN_W-1:0] bin_sr, bin_n;
  logic [BCD_W-1:0] scr, scr_n;
  logic             ovf_pend, ovf_pend_n;
  logic [BCD_W-1:0] bcd_q, bcd_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             ovf_q, ovf_n;

  logic [BCD_W-1:0] adj;
  logic [BCD_W-1:0] scr_sh;
  logic [BIN_W-1:0] bin_sh;
  logic             over;

  // Per-digit add-3 correction of the scratch register
  for (genvar d = 0; d < DIGITS; d++) begin : g_dab
    dabble_digit u_dab (
      .din  (scr[4*d +: 4]),
      .dout (adj[4*d +: 4])
    );
  end

  assign scr_sh = {adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign bin_sh = {bin_sr[BIN_W-2:0], 1'b0};
  assign over   = bus.Bin > MAX_BIN;

  // State and datapath registers; reset wins over any request
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bin_sr   <= '0;
      scr      <= '0;
      ovf_pend <= 1'b0;
      bcd_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bin_sr   <= bin_n;
      scr      <= scr_n;
      ovf_pend <= ovf_pend_n;
      bcd_q    <= bcd_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      ovf_q    <= ovf_n;
    end
  end

  // Next-state: load on Start, shift BIN_W times, publish on the last
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bin_n      = bin_sr;
    scr_n      = scr;
    ovf_pend_n = ovf_pend;
    bcd_n      = bcd_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    ovf_n      = ovf_q;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          bin_n      = over ? MAX_BIN : bus.Bin;
          ovf_pend_n = over;
          scr_n      = '0;
          cnt_n      = '0;
          busy_n     = 1'b1;
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        bin_n = bin_sh;
        scr_n = scr_sh;
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          bcd_n   = scr_sh;
          ovf_n   = ovf_pend;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.BCD      = bcd_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq.
// Vector table, hand-written corner sequences and random reference checks.
module tb_bin_to_bcd_seq;

  logic CLK = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  bin_to_bcd_seq_if bus ();

  bin_to_bcd_seq dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    int x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int b, input logic [15:0] eb, input logic eo,
                     input string tag);
    int          n;
    bit          stable;
    logic [15:0] prev;
    prev = bus.BCD;
    bus.Start = 1'b1;
    bus.Bin = 14'(b);
    step();
    bus.Start = 1'b0;
    bus.Bin = 14'($urandom);
    n = 0;
    stable = 1'b1;
    while (!bus.Done && n < 40) begin
      if (!bus.Busy || bus.BCD !== prev) stable = 1'b0;
      step();
      n++;
    end
    chk({tag, " latency"}, n, 14);
    chk({tag, " busy/bcd stable"}, 32'(stable), 1);
    chk({tag, " bcd"}, bus.BCD, eb);
    chk({tag, " ovf"}, bus.Overflow, eo);
    chk({tag, " busy at done"}, bus.Busy, 0);
    step();
    chk({tag, " done drop"}, bus.Done, 0);
  endtask

  initial begin
    int n, m, dn;
    vecs[0] = '{1234,  16'h1234, 1'b0};
    vecs[1] = '{0,     16'h0000, 1'b0};
    vecs[2] = '{9999,  16'h9999, 1'b0};
    vecs[3] = '{12000, 16'h9999, 1'b1};
    vecs[4] = '{42,    16'h0042, 1'b0};
    vecs[5] = '{10000, 16'h9999, 1'b1};
    vecs[6] = '{16383, 16'h9999, 1'b1};
    vecs[7] = '{5000,  16'h5000, 1'b0};
    vecs[8] = '{1,     16'h0001, 1'b0};
    vecs[9] = '{9990,  16'h9990, 1'b0};

    Reset = 1'b1;
    bus.Start = 1'b0;
    bus.Bin = '0;
    step();
    step();
    chk("reset bcd", bus.BCD, 0);
    chk("reset busy", bus.Busy, 0);
    chk("reset done", bus.Done, 0);
    chk("reset ovf", bus.Overflow, 0);
    Reset = 1'b0;
    step();

    foreach (vecs[i])
      run(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));

    // Held Start with Bin changing while busy, then back-to-back accept
    bus.Start = 1'b1;
    bus.Bin = 14'd5678;
    step();
    bus.Bin = 14'd1111;
    chk("b2b busy", bus.Busy, 1);
    n = 0;
    while (!bus.Done && n < 40) begin
      step();
      n++;
    end
    chk("b2b first latency", n, 14);
    chk("b2b first bcd", bus.BCD, 16'h5678);
    step();
    bus.Start = 1'b0;
    chk("b2b second busy", bus.Busy, 1);
    chk("b2b done once", bus.Done, 0);
    m = 1;
    while (!bus.Done && m < 40) begin
      step();
      m++;
    end
    chk("b2b second latency", m, 15);
    chk("b2b second bcd", bus.BCD, 16'h1111);
    dn = 0;
    repeat (20) begin
      step();
      if (bus.Done) dn++;
    end
    chk("b2b extra done", dn, 0);

    // Reset in the middle of a conversion
    run(42, 16'h0042, 1'b0, "pre42");
    bus.Start = 1'b1;
    bus.Bin = 14'd8765;
    step();
    bus.Start = 1'b0;
    repeat (7) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("abort bcd", bus.BCD, 0);
    chk("abort busy", bus.Busy, 0);
    chk("abort done", bus.Done, 0);
    dn = 0;
    repeat (20) begin
      step();
      if (bus.Done || bus.Busy) dn++;
    end
    chk("abort quiet", dn, 0);
    run(8765, 16'h8765, 1'b0, "post8765");

    // Start and Reset on the same edge: Start is lost
    bus.Start = 1'b1;
    bus.Bin = 14'd77;
    Reset = 1'b1;
    step();
    bus.Start = 1'b0;
    Reset = 1'b0;
    dn = 0;
    repeat (20) begin
      if (bus.Done || bus.Busy) dn++;
      step();
    end
    chk("start+reset lost", dn, 0);
    chk("start+reset bcd", bus.BCD, 0);

    for (int v = 9995; v <= 10005; v++)
      run(v, ref_bcd(v), 1'(v > 9999), $sformatf("edge%0d", v));

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10000, 16383))
                                      : int'($urandom_range(0, 9999));
      run(r, ref_bcd(r), 1'(r > 9999), $sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
